// File: rtl/mult_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_issue_ctrl
// Description : Issue sequencer in front of a WxW unsigned shift-add
//               multiplier. Operand pairs arrive over valid/ready and are
//               queued in a small FIFO. Each pair is handed to the
//               multiplier with a one-cycle start pulse. The product is
//               captured into a registered valid/ready result slot.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream operand handshake (in_ready = FIFO not full)
//   in_mplier/in_mcand  incoming operand pair
//   mult_st             one-cycle start pulse to the multiplier
//   mult_mplier/mcand   registered operands, held from pop to next pop
//   mult_prod/done      product and completion from the multiplier
//   res_valid/ready     downstream result handshake
//   res_prod            captured 2W-bit product
//   busy                sequencer not idle
//   err                 sticky timeout flag
//   ops_count           completed products, wraps at 16 bits
// ============================================================================
module mult_issue_ctrl #(
  parameter int W       = 10,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_mplier,
  input  logic [W-1:0]   in_mcand,
  output logic           mult_st,
  output logic [W-1:0]   mult_mplier,
  output logic [W-1:0]   mult_mcand,
  input  logic [2*W-1:0] mult_prod,
  input  logic           mult_done,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_prod,
  output logic           busy,
  output logic           err,
  output logic [15:0]    ops_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mem_mplier_q [DEPTH];
  logic [W-1:0]    mem_mcand_q  [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic            res_valid_q, res_valid_d;
  logic [2*W-1:0]  res_prod_q, res_prod_d;
  logic            err_q, err_d;
  logic [15:0]     ops_q, ops_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic full, empty, push, pop;

  // Full is judged on the registered count only: a same-cycle pop does not
  // open a slot for a push-through.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;

  always_comb begin
    state_d     = state_q;
    mplier_d    = mplier_q;
    mcand_d     = mcand_q;
    res_valid_d = res_valid_q;
    res_prod_d  = res_prod_q;
    err_d       = err_q;
    ops_d       = ops_q;
    tmo_d       = tmo_q;
    pop         = 1'b0;

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only issue when the result slot is free or being drained now,
        // so a later capture can never overwrite an unconsumed product.
        if (!empty && (!res_valid_q || res_ready)) begin
          pop      = 1'b1;
          mplier_d = mem_mplier_q[rd_ptr_q];
          mcand_d  = mem_mcand_q[rd_ptr_q];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // mult_done is deliberately ignored here.
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mult_done) begin
          res_prod_d  = mult_prod;
          res_valid_d = 1'b1;
          ops_d       = ops_q + 16'd1;
          state_d     = S_IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mplier_q    <= '0;
      mcand_q     <= '0;
      res_valid_q <= 1'b0;
      res_prod_q  <= '0;
      err_q       <= 1'b0;
      ops_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mplier_q    <= mplier_d;
      mcand_q     <= mcand_d;
      res_valid_q <= res_valid_d;
      res_prod_q  <= res_prod_d;
      err_q       <= err_d;
      ops_q       <= ops_d;
      tmo_q       <= tmo_d;
    end
  end

  // Storage needs no reset: entries are only read below the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_mplier_q[wr_ptr_q] <= in_mplier;
      mem_mcand_q[wr_ptr_q]  <= in_mcand;
    end
  end

  assign in_ready    = !full;
  assign mult_st     = (state_q == S_ISSUE);
  assign mult_mplier = mplier_q;
  assign mult_mcand  = mcand_q;
  assign res_valid   = res_valid_q;
  assign res_prod    = res_prod_q;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign ops_count   = ops_q;

endmodule
`default_nettype wire
